risky_fetch: RTL and testbench
==============================

Name: risky_fetch

Overview:
Instruction-fetch front end of the risky core. Generates the PC stream and issues reads to a synchronous instruction memory with 1-cycle latency. Buffers returned words in a small queue and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, which flush all queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
QUEUE_DEPTH, 4, instruction queue entries; power of 2, >= 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request to instruction memory this cycle
imem_addr  out  32  byte address of the request; bits [1:0] always 0
imem_rdata  in  32  read data, valid the cycle after an accepted imem_req
if_valid  out  1  queue head holds a valid instruction
if_instr  out  32  instruction word at queue head
if_pc  out  32  address of if_instr
if_ready  in  1  decode accepts the head this cycle
redirect_valid  in  1  execute requests a PC change
redirect_pc  in  32  new fetch address

Behaviour:
- Reset (async assert, rst_n=0): fetch_pc=RESET_PC; queue count=0; inflight=0; started=0; epoch=0.
- Outputs while in reset: imem_req=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC.
- started is set at the first posedge with rst_n=1. imem_req is held at 0 until started=1.
- Request condition, combinational: imem_req = started && !redirect_valid && (count + inflight < QUEUE_DEPTH).
- imem_addr = fetch_pc whenever imem_req=1.
- On an issued request:
  - inflight <= 1; the request's epoch and PC are recorded.
  - fetch_pc <= fetch_pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Memory response (cycle after an issued request): imem_rdata is enqueued with its PC when the recorded epoch matches the current epoch; otherwise it is discarded. inflight clears in either case.
- Latency: a request in cycle t is enqueued at the end of t+1; if_valid is high in cycle t+2.
- Steady state with if_ready=1: one instruction per cycle.
- Dequeue: occurs when if_valid && if_ready. The head advances and count decrements.
- Enqueue and dequeue in the same cycle are both performed, including when count=QUEUE_DEPTH. Request gating guarantees an enqueue never overflows.
- if_valid = (count != 0). if_instr and if_pc must be held stable while if_valid=1 and if_ready=0.
- Redirect (redirect_valid=1 at a posedge):
  - count <= 0; any same-cycle dequeue or enqueue is ignored.
  - epoch toggles, so an in-flight response is dropped next cycle.
  - fetch_pc <= redirect_pc with bits [1:0] forced to 0.
  - No request is issued in the redirect cycle. The first request to redirect_pc is issued the next cycle, provided redirect_valid is deasserted.
  - if_valid=0 the cycle after a redirect.
- Back-to-back redirects: the last one wins.
- Redirect during the started=0 cycle: takes effect normally.
- Reset mid-operation: all state returns to reset values immediately. A response arriving after reset release is never enqueued, because inflight=0.

Optional Feature:
Macro RISKY_FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port fetch_misaligned (1 bit), reset 0.
  - Set when redirect_valid=1 and redirect_pc[1:0] != 0; stays set (sticky) until reset.
  - A misaligned redirect still flushes the queue and fetch_pc still takes the forced-aligned address.
- Undefined: the port is absent and redirect_pc[1:0] are silently ignored.

Test Plan:
1. Reset with RESET_PC=0, release rst_n, if_ready=1 -> imem_req=0 in the first cycle. Requests to addresses 0, 4, 8… follow. if_valid rises 2 cycles after the first request; if_pc goes 0, 4, 8 with matching if_instr.
2. Hold if_ready=0 -> exactly 4 instructions are queued and imem_req drops. Raise if_ready -> PCs 0, 4, 8, 12, 16… are delivered at 1/cycle with no gap and no duplicate.
3. Pulse redirect_valid with redirect_pc=32'h100 while a request to 0x10 is in flight -> 0x10 is never presented and if_valid=0 the next cycle. The next request is to 0x100 and if_pc=0x100 arrives 2 cycles after it.
4. RESET_PC=32'hFFFF_FFF8 -> fetch order is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
5. Assert redirect_valid in the same cycle as a full-queue dequeue, then assert rst_n=0 mid-stream -> the queue is empty after the redirect edge, and all outputs return to reset values immediately on reset.
6. With RISKY_FETCH_MISALIGN_CHECK_EN defined, redirect to 32'h102 -> fetch_misaligned=1 and stays set, and the next imem_addr=32'h100. With the macro undefined, the same stimulus gives imem_addr=32'h100 and no flag.

Source files
------------

// File: rtl/risky_fetch.sv
// rtl/risky_fetch.sv - risky core instruction-fetch front end with PC generation, fetch queue and redirect flush
// Optional build macro: RISKY_FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misaligned flag.
module risky_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic          r_inflight;
    logic          r_started;
    logic          r_epoch;
    logic          r_req_epoch;
    logic [31:0]   r_req_pc;
    logic [31:0]   r_q_instr [QUEUE_DEPTH];
    logic [31:0]   r_q_pc    [QUEUE_DEPTH];

    logic          w_valid;
    logic          w_req;
    logic          w_enq;
    logic          w_deq;

    // count + inflight never exceeds QUEUE_DEPTH, so an accepted response always has a free slot
    assign w_valid = (r_count != '0);
    assign w_req   = r_started && !redirect_valid &&
                     ((r_count + CW'(r_inflight)) < CW'(QUEUE_DEPTH));
    assign w_enq   = r_inflight && (r_req_epoch == r_epoch);
    assign w_deq   = w_valid && if_ready;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = w_valid;
    assign if_instr  = w_valid ? r_q_instr[r_head] : 32'h0;
    assign if_pc     = w_valid ? r_q_pc[r_head]    : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_inflight  <= 1'b0;
            r_started   <= 1'b0;
            r_epoch     <= 1'b0;
            r_req_epoch <= 1'b0;
            r_req_pc    <= 32'h0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                // flush wins over any same-cycle enqueue or dequeue
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_inflight <= 1'b0;
                r_epoch    <= ~r_epoch;
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                r_inflight <= w_req;
                if (w_req) begin
                    r_fetch_pc  <= r_fetch_pc + 32'd4;
                    r_req_epoch <= r_epoch;
                    r_req_pc    <= r_fetch_pc;
                end
                if (w_enq) r_tail <= r_tail + 1'b1;
                if (w_deq) r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq && !redirect_valid) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pc[r_tail]    <= r_req_pc;
        end
    end

`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end
    assign fetch_misaligned = r_misaligned;
`else
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = &{1'b0, redirect_pc[1:0]};
`endif
endmodule

// File: tb/tb_risky_fetch.sv
// tb/tb_risky_fetch.sv - self-checking bench for risky_fetch (vector table, corner sequences, random scoreboard)
module tb_risky_fetch;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        if_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req2, if_valid2;
    logic [31:0] imem_addr2, if_instr2, if_pc2;
    logic [31:0] imem_rdata2 = 32'h0;
    logic        mis, mis2;

    int n_cmp = 0;
    int n_bad = 0;

    risky_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
        , .fetch_misaligned(mis)
`endif
    );

    risky_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
        .if_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
        , .fetch_misaligned(mis2)
`endif
    );

`ifndef RISKY_FETCH_MISALIGN_CHECK_EN
    assign mis  = 1'b0;
    assign mis2 = 1'b0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= mem_word(imem_addr);
        if (imem_req2) imem_rdata2 <= mem_word(imem_addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[14];

    logic [31:0] exp_f, exp_d;
    logic        prev_redir, exp_mis, found;
    int          n_deliv;
    logic [31:0] wrap_req[$];
    logic [31:0] wrap_pc[$];
    logic [31:0] wrap_exp[4];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
        vecs[9]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
        vecs[10] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        vecs[11] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vecs[12] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        vecs[13] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};

        rst_n = 1'b0; rst2_n = 1'b0;
        if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_mis", mis, 0);

        // startup, fill to full, drain at one per cycle
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
            if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_valid", i), if_valid, vecs[i].vld);
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_pc", i), if_pc, vecs[i].pc);
                chk($sformatf("vec%0d_instr", i), if_instr, mem_word(vecs[i].pc));
            end
            @(negedge clk);
        end

        // redirect while the request to 0x10 is in flight
        do_reset();
        if_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
            @(negedge clk);
        end
        chk("redir_found_0x10", found, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("redir_no_req", imem_req, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("redir_valid_next", if_valid, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h100);
        @(negedge clk); #1;
        chk("redir_valid_2", if_valid, 0);
        @(negedge clk); #1;
        chk("redir_valid_3", if_valid, 1);
        chk("redir_pc_3", if_pc, 32'h100);
        chk("redir_instr_3", if_instr, mem_word(32'h100));

        // redirect with a full queue and a same-cycle dequeue, then reset mid-stream
        do_reset();
        if_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("full_valid", if_valid, 1);
        chk("full_noreq", imem_req, 0);
        chk("full_pc", if_pc, 0);
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("flush_valid", if_valid, 0);
        chk("flush_addr", imem_addr, 32'h40);
        @(negedge clk); @(negedge clk); #1;
        chk("flush_pc", if_pc, 32'h40);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_valid", if_valid, 0);
        chk("midrst_instr", if_instr, 0);
        chk("midrst_pc", if_pc, 0);
        chk("midrst_addr", imem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", imem_req, 0);
        @(negedge clk); #1;
        chk("post_rst_valid", if_valid, 0);

        // misaligned redirect
        do_reset();
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("mis_req", imem_req, 1);
        chk("mis_addr", imem_addr, 32'h100);
`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", mis, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("mis_flag_sticky", mis, 1);
`endif

        // PC wrap-around from RESET_PC = FFFF_FFF8
        @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req2) wrap_req.push_back(imem_addr2);
            if (if_valid2) begin
                wrap_pc.push_back(if_pc2);
                chk("wrap_instr", if_instr2, mem_word(if_pc2));
            end
            @(negedge clk);
        end
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        chk("wrap_nreq", (wrap_req.size() >= 4), 1);
        chk("wrap_npc", (wrap_pc.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < wrap_req.size()) chk($sformatf("wrap_req%0d", i), wrap_req[i], wrap_exp[i]);
            if (i < wrap_pc.size())  chk($sformatf("wrap_pc%0d", i), wrap_pc[i], wrap_exp[i]);
        end

        // random stimulus against the in-order delivery model
        do_reset();
        exp_f = 32'h0; exp_d = 32'h0; prev_redir = 1'b0; exp_mis = 1'b0; n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            if_ready       = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(1) == 0) redirect_pc[1:0] = 2'b00;
            #1;
            if (redirect_valid) chk("rnd_req_in_redirect", imem_req, 0);
            if (imem_req) begin
                chk("rnd_addr", imem_addr, exp_f);
                exp_f = exp_f + 32'd4;
            end
            if (prev_redir) chk("rnd_valid_after_redirect", if_valid, 0);
            if (if_valid && if_ready) begin
                chk("rnd_pc", if_pc, exp_d);
                chk("rnd_instr", if_instr, mem_word(exp_d));
                exp_d = exp_d + 32'd4;
                n_deliv++;
            end
`ifdef RISKY_FETCH_MISALIGN_CHECK_EN
            chk("rnd_mis", mis, exp_mis);
            if (redirect_valid && redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
`endif
            if (redirect_valid) begin
                exp_f = {redirect_pc[31:2], 2'b00};
                exp_d = exp_f;
            end
            prev_redir = redirect_valid;
            @(negedge clk);
        end
        chk("rnd_throughput", (n_deliv > 600), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
